// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// MULT/MULTU use a shift-add over a 2*WIDTH working product, and DIV/DIVU
// use restoring division. Both produce one bit per cycle. MTHI/MTLO write
// HI/LO directly. HI/LO change only when a result is committed, so they are
// stable for MFHI/MFLO for the whole of a multiply/divide.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Absolute value of a two's-complement operand. Unsigned ops pass it
    // through unchanged. The most negative value maps onto itself, which
    // is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic            is_signed);
        logic signed [WIDTH-1:0] v_s;
        v_s = v;
        if (is_signed && (v_s < 0))
            magnitude = ~v + WIDTH'(1);
        else
            magnitude = v;
    endfunction

    // Conditionally negate a WIDTH-bit result, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic            neg);
        cond_neg = neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Conditionally negate the full 2*WIDTH-bit product.
    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                     input logic              neg);
        cond_neg2 = neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  work_q, work_d;    // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]    opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;  // negate product / quotient
    logic                neg_rem_q, neg_rem_d;  // negate remainder
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;

    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH-1:0]  mul_next;
    logic [WIDTH:0]      div_shift;
    logic [WIDTH:0]      div_diff;
    logic [2*WIDTH-1:0]  div_next;

    logic                op_signed;
    logic                op_is_div;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;

    // One iteration step for each algorithm, computed from the working registers
    always_comb begin
        // Shift-add: add the multiplicand when the multiplier LSB is set, then shift right
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
        // Restoring divide: shift in the next dividend bit and try to subtract the divisor.
        // The remainder is always below the divisor, so the shifted value fits in WIDTH+1
        // bits and the top bit of the difference is the borrow.
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[WIDTH])
            div_next = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end

    // Next-state logic: accept in IDLE, iterate in RUN, commit on the last step
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
        a_mag     = magnitude(operand_a, op_signed);
        b_mag     = magnitude(operand_b, op_signed);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            if (op_is_div && (operand_b == '0)) begin
                                // Zero divisor: report it at once and leave HI/LO alone
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                state_d   = S_RUN;
                                busy_d    = 1'b1;
                                cnt_d     = '0;
                                is_div_d  = op_is_div;
                                neg_res_d = op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                                neg_rem_d = op_signed && operand_a[WIDTH-1];
                                opnd_d    = op_is_div ? b_mag : a_mag;
                                work_d    = {{WIDTH{1'b0}}, (op_is_div ? a_mag : b_mag)};
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = operand_a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = operand_a;
                            done_d = 1'b1;
                        end
                        default: ; // reserved opcodes are ignored
                    endcase
                end
            end
            S_RUN: begin
                work_d = is_div_q ? div_next : mul_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    if (is_div_q) begin
                        lo_d = cond_neg(div_next[WIDTH-1:0], neg_res_q);
                        hi_d = cond_neg(div_next[2*WIDTH-1:WIDTH], neg_rem_q);
                    end else begin
                        {hi_d, lo_d} = cond_neg2(mul_next, neg_res_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit. Expected results are queued when an
// op is issued and popped when done is seen.
module tb_mips_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .hi(hi),
        .lo(lo)
    );

    function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic d);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.dbz = d;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, then compare against the scoreboard
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e, input bit long_op);
        int   cycles;
        int   busy_cycles;
        bit   seen;
        exp_t got_e;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; operand_a = $urandom; operand_b = $urandom;
        cycles = 0; busy_cycles = 0; seen = 1'b0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(cycles), long_op ? 64'd33 : 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), long_op ? 64'd32 : 64'd0);
        if (seen && sb_q.size() > 0) begin
            got_e = sb_q.pop_front();
            check({tag, "_hi"}, 64'(hi), 64'(got_e.hi));
            check({tag, "_lo"}, 64'(lo), 64'(got_e.lo));
            check({tag, "_dbz"}, 64'(div_by_zero), 64'(got_e.dbz));
            m_hi = got_e.hi;
            m_lo = got_e.lo;
        end
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done), 64'd0);
        check({tag, "_dbz_low"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cycles;
        int          done_cnt;
        bit          seen;
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;

        rst = 1'b1; start = 1'b0; op = 3'b000; operand_a = '0; operand_b = '0;
        m_hi = '0; m_lo = '0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Multiply
        do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'hFFFFFFFE, 32'h00000001, 1'b0), 1'b1);
        do_op("mult_neg3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0), 1'b1);
        do_op("mult_minxmin", OP_MULT, 32'h80000000, 32'h80000000, mk(32'h40000000, 32'h00000000, 1'b0), 1'b1);

        // Divide
        do_op("div_neg7by2", OP_DIV, 32'hFFFFFFF9, 32'd2, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0), 1'b1);
        do_op("divu_100by7", OP_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), 1'b1);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, mk(32'h00000000, 32'h80000000, 1'b0), 1'b1);

        // Random operands against a reference model
        for (int i = 0; i < 2; i++) begin
            ra = $urandom; rb = $urandom;
            sp = longint'($signed(ra)) * longint'($signed(rb));
            do_op("mult_rand", OP_MULT, ra, rb, mk(sp[63:32], sp[31:0], 1'b0), 1'b1);
            ra = $urandom; rb = $urandom;
            up = {32'd0, ra} * {32'd0, rb};
            do_op("multu_rand", OP_MULTU, ra, rb, mk(up[63:32], up[31:0], 1'b0), 1'b1);
            ra = $urandom; rb = $urandom_range(1, 65535);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (rb == 32'hFFFFFFFF) rb = 32'd3;
            q = $signed(ra) / $signed(rb);
            r = $signed(ra) % $signed(rb);
            do_op("div_rand", OP_DIV, ra, rb, mk(r, q, 1'b0), 1'b1);
            ra = $urandom; rb = $urandom_range(1, 32'hFFFFFFFF);
            do_op("divu_rand", OP_DIVU, ra, rb, mk(ra % rb, ra / rb, 1'b0), 1'b1);
        end

        // Divide by zero with preloaded HI/LO
        do_op("mthi_aa", OP_MTHI, 32'hAAAAAAAA, 32'd0, mk(32'hAAAAAAAA, m_lo, 1'b0), 1'b0);
        do_op("mtlo_55", OP_MTLO, 32'h55555555, 32'd0, mk(32'hAAAAAAAA, 32'h55555555, 1'b0), 1'b0);
        do_op("divu_by0", OP_DIVU, 32'd5, 32'd0, mk(32'hAAAAAAAA, 32'h55555555, 1'b1), 1'b0);

        // start held through busy and through the commit edge must be ignored
        sb_q.push_back(mk(32'd0, 32'd12, 1'b0));
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd4;
        @(posedge clk);
        #1;
        operand_a = 32'd5; operand_b = 32'd6;
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("hs_done_seen", 64'(seen), 64'd1);
        check("hs_latency", 64'(cycles), 64'd33);
        if (seen && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("hs_hi", 64'(hi), 64'(e.hi));
            check("hs_lo", 64'(lo), 64'(e.lo));
            m_hi = e.hi; m_lo = e.lo;
        end
        @(negedge clk);
        check("hs_no_accept_busy", 64'(busy), 64'd0);
        check("hs_no_accept_done", 64'(done), 64'd0);

        do_op("mthi_1234", OP_MTHI, 32'h12345678, 32'd0, mk(32'h12345678, m_lo, 1'b0), 1'b0);

        // Reserved opcode: nothing happens
        @(negedge clk);
        start = 1'b1; op = 3'b110; operand_a = 32'hDEADBEEF; operand_b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("rsv_no_activity", 64'(done_cnt), 64'd0);
        check("rsv_hi", 64'(hi), 64'(m_hi));
        check("rsv_lo", 64'(lo), 64'(m_lo));

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mid_rst_no_done", 64'(done_cnt), 64'd0);
        do_op("multu_2x3", OP_MULTU, 32'd2, 32'd3, mk(32'd0, 32'd6, 1'b0), 1'b1);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Consumes the two register-file read operands (rs, rt) in the execute stage and runs MULT, MULTU, DIV, DIVU over multiple cycles with a busy/done handshake. Also executes MTHI and MTLO, and exposes HI/LO continuously for MFHI/MFLO.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted on a rising edge where start=1 and busy=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- operand_a  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO source
- operand_b  in  WIDTH  rt value: multiplier or divisor
- busy  out  1  high while a multiply/divide iterates
- done  out  1  one-cycle pulse when a result or error is committed
- div_by_zero  out  1  high together with done when a DIV/DIVU had a zero divisor
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

## Operation
- States: IDLE and RUN.
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, step counter=0.
- Accept, IDLE only. On the accepting edge E0:
  - Capture both operands.
  - For MULT/DIV, convert each operand to its magnitude and record the result signs.
  - Enter RUN with the counter at 0.
- Reserved op: a start with op 110/111 is ignored. No state change and no done.
- MTHI/MTLO: at E0, write operand_a into hi (MTHI) or lo (MTLO). done=1 in the following cycle. busy is never asserted.
- DIV/DIVU with operand_b=0:
  - Detected at E0. No RUN.
  - hi/lo unchanged. done=1 and div_by_zero=1 in the following cycle.
- Multiply: shift-add over a 2*WIDTH working product, one multiplier bit per RUN edge.
- Divide: restoring division, one quotient bit per RUN edge.
- Working registers are separate from hi/lo. hi/lo hold their old values for the entire RUN.
- Commit on the WIDTH-th RUN edge:
  - Multiply: {hi,lo} = 2*WIDTH-bit product. For MULT, the product is negated if the operand signs differ.
  - Divide: lo = quotient, hi = remainder.
  - DIV quotient truncates toward zero; its sign is dividend sign XOR divisor sign. Remainder sign follows the dividend.
  - All arithmetic is modulo 2^WIDTH per half. DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- start while busy=1 is ignored: no queuing, and operands are not re-sampled.
- start on the same edge that commits (busy still 1) is ignored. The new op must be presented from the next cycle on.
- Reset mid-RUN aborts immediately: all outputs return to reset values and no done is generated.

## Timing
- Multiply/divide latency: accept at edge E0. busy=1 from E0 through E(WIDTH), which is WIDTH cycles.
- At E(WIDTH): hi/lo update, done=1 for exactly one cycle, busy=0.
- Back-to-back: the earliest next accept is E(WIDTH+1). This gives a throughput of one op per WIDTH+1 cycles.
- MTHI/MTLO and divide-by-zero: result and done are visible one cycle after E0.
- done is never high for more than one consecutive cycle per accepted op. div_by_zero is only ever high while done is high.
- hi/lo are register outputs with no combinational path from the inputs.

## Test plan
- Unsigned multiply: MULTU 0xFFFFFFFF x 0xFFFFFFFF.
  - hi=0xFFFFFFFE, lo=0x00000001.
  - busy high exactly 32 cycles; done pulses once in the cycle after the 32nd RUN edge.
- Signed multiply: MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- Divide:
  - DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100 / 7 -> lo=14, hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0xAAAAAAAA, lo=0x55555555 via MTHI/MTLO, then DIVU 5 / 0.
  - done=1 and div_by_zero=1 one cycle after accept.
  - busy stays 0; hi/lo unchanged.
- Handshake:
  - Start MULTU 3x4; hold start with MULTU 5x6 during busy -> result stays hi=0, lo=12.
  - MTHI 0x12345678 afterwards -> hi=0x12345678 next cycle, with a done pulse.
  - Reserved op 110 -> no done, hi/lo unchanged.
- Reset mid-RUN: assert rst asynchronously at RUN step 10 of DIVU 100/7.
  - busy/done/hi/lo go to 0 without waiting for a clock edge; no done is seen.
  - A subsequent MULTU 2x3 yields lo=6.
